// File: rtl/imem_load_ctrl_if.sv
// Bundle of loader, fetch, status and memory-port signals for imem_load_ctrl.
// slave = controller side, master = environment (loader/CPU/memory) side.
interface imem_load_ctrl_if #(
    parameter int unsigned ADRBITS = 10
);
    logic               ld_valid;
    logic [31:0]        ld_data;
    logic               ld_last;
    logic               ld_ready;
    logic               reload;
    logic               fetch_req;
    logic [31:0]        fetch_pc;
    logic               fetch_valid;
    logic [31:0]        fetch_instr;
    logic               fetch_err;
    logic               cpu_run;
    logic [ADRBITS:0]   load_count;
    logic               trunc;
    logic [ADRBITS-1:0] mem_addr;
    logic               mem_we;
    logic [31:0]        mem_wdata;
    logic [31:0]        mem_rdata;

    modport slave (
        input  ld_valid, ld_data, ld_last, reload, fetch_req, fetch_pc, mem_rdata,
        output ld_ready, fetch_valid, fetch_instr, fetch_err, cpu_run,
               load_count, trunc, mem_addr, mem_we, mem_wdata
    );

    modport master (
        output ld_valid, ld_data, ld_last, reload, fetch_req, fetch_pc, mem_rdata,
        input  ld_ready, fetch_valid, fetch_instr, fetch_err, cpu_run,
               load_count, trunc, mem_addr, mem_we, mem_wdata
    );
endinterface

// File: rtl/imem_load_ctrl.sv
// Owns the single instruction-memory port: streams boot-loader words into
// memory, then serves CPU fetch reads until a reload pulse restarts loading.
module imem_load_ctrl #(
    parameter int unsigned ADRBITS = 10
) (
    input  logic            clk,
    input  logic            reset,
    imem_load_ctrl_if.slave bus
);
    typedef enum logic {
        S_LOAD = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [ADRBITS-1:0] r_wr_ptr;
    logic [ADRBITS-1:0] w_wr_ptr_nxt;
    logic [ADRBITS:0]   r_load_count;
    logic [ADRBITS:0]   w_load_count_nxt;
    logic               r_trunc;
    logic               w_trunc_nxt;
    logic               r_cpu_run;
    logic               r_fetch_valid;
    logic               r_fetch_err;

    logic               w_ld_acc;
    logic               w_at_top;
    logic               w_fetch_acc;
    logic               w_misaligned;
    logic [ADRBITS-1:0] w_fetch_idx;
    logic               w_unused_pc;

    assign w_fetch_idx  = bus.fetch_pc[ADRBITS+1:2];
    assign w_misaligned = |bus.fetch_pc[1:0];
    assign w_unused_pc  = ^bus.fetch_pc[31:ADRBITS+2];
    assign w_at_top     = (r_wr_ptr == '1);
    assign w_ld_acc     = (r_state == S_LOAD) && bus.ld_valid;
    // Reload takes priority over a fetch issued in the same cycle.
    assign w_fetch_acc  = (r_state == S_RUN) && bus.fetch_req && !bus.reload;

    always_comb begin
        w_state_nxt      = r_state;
        w_wr_ptr_nxt     = r_wr_ptr;
        w_load_count_nxt = r_load_count;
        w_trunc_nxt      = r_trunc;
        case (r_state)
            S_LOAD: begin
                if (w_ld_acc) begin
                    w_load_count_nxt = r_load_count + 1'b1;
                    if (!w_at_top) begin
                        w_wr_ptr_nxt = r_wr_ptr + 1'b1;
                    end
                    if (bus.ld_last) begin
                        w_state_nxt = S_RUN;
                    end else if (w_at_top) begin
                        w_trunc_nxt = 1'b1;
                        w_state_nxt = S_RUN;
                    end
                end
            end
            S_RUN: begin
                w_state_nxt = S_RUN;
            end
            default: begin
                w_state_nxt = S_LOAD;
            end
        endcase
        // A word accepted alongside reload is still written; only the
        // bookkeeping restarts.
        if (bus.reload) begin
            w_state_nxt      = S_LOAD;
            w_wr_ptr_nxt     = '0;
            w_load_count_nxt = '0;
            w_trunc_nxt      = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= S_LOAD;
            r_wr_ptr      <= '0;
            r_load_count  <= '0;
            r_trunc       <= 1'b0;
            r_cpu_run     <= 1'b0;
            r_fetch_valid <= 1'b0;
            r_fetch_err   <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_wr_ptr      <= w_wr_ptr_nxt;
            r_load_count  <= w_load_count_nxt;
            r_trunc       <= w_trunc_nxt;
            r_cpu_run     <= (w_state_nxt == S_RUN);
            r_fetch_valid <= w_fetch_acc;
            r_fetch_err   <= w_fetch_acc && w_misaligned;
        end
    end

    assign bus.ld_ready   = (r_state == S_LOAD);
    assign bus.mem_we     = w_ld_acc;
    assign bus.mem_addr   = (r_state == S_LOAD) ? r_wr_ptr : w_fetch_idx;
    assign bus.mem_wdata  = bus.ld_data;
    assign bus.cpu_run    = r_cpu_run;
    assign bus.load_count = r_load_count;
    assign bus.trunc      = r_trunc;

    // mem_rdata is already the memory's registered read; masking it here keeps
    // the instruction aligned with the registered fetch_valid/fetch_err.
    assign bus.fetch_valid = r_fetch_valid;
    assign bus.fetch_err   = r_fetch_err;
    assign bus.fetch_instr = (r_fetch_valid && !r_fetch_err) ? bus.mem_rdata : '0;
endmodule
